// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, issue FSM state type and default data width.
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] ALU_FADD = 3'd4;
  localparam logic [2:0] ALU_FSUB = 3'd5;
  localparam logic [2:0] ALU_CMP  = 3'd6;
  localparam logic [2:0] ALU_NOP  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } issue_state_e;

endpackage

// File: rtl/alu_issue_timer.sv
// Loadable up-counter with synchronous clear; o_tc flags count == i_term.
// Clear has priority over load, load over increment.
module alu_issue_timer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc = (cnt_q == i_term);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Serialises one command at a time to the ALU: issue pulse, wait for done or timeout, return result.
// Optional saturating statistics counters are built when ALU_ISSUE_STATS_EN is defined.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W         = ALU_DATA_W,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [2:0]        i_cmd_op,
  input  logic [2:0]        i_cmd_ctrl,
  input  logic [DATA_W-1:0] i_cmd_a,
  input  logic [DATA_W-1:0] i_cmd_b,
  output logic              o_alu_valid,
  output logic [2:0]        o_alu_op,
  output logic [2:0]        o_alu_ctrl,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  input  logic              i_alu_done,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic              i_alu_comp,
  input  logic              i_alu_invalid,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [DATA_W-1:0] o_res_data,
  output logic              o_res_comp,
  output logic              o_res_invalid,
  output logic              o_res_timeout
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [CNT_W-1:0]  o_stat_issued,
  output logic [CNT_W-1:0]  o_stat_invalid,
  output logic [CNT_W-1:0]  o_stat_timeout
`endif
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  issue_state_e      state_q;
  logic              alu_valid_q;
  logic [2:0]        alu_op_q;
  logic [2:0]        alu_ctrl_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_comp_q;
  logic              res_invalid_q;
  logic              res_timeout_q;
  logic              tmo_tc;

  // Counter is zeroed in ISSUE so the first WAIT cycle sees 0.
  alu_issue_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (state_q == ST_ISSUE),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (state_q == ST_WAIT),
    .i_term     (TERM),
    .o_tc       (tmo_tc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      alu_valid_q   <= 1'b0;
      alu_op_q      <= '0;
      alu_ctrl_q    <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_comp_q    <= 1'b0;
      res_invalid_q <= 1'b0;
      res_timeout_q <= 1'b0;
    end else begin
      alu_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            alu_op_q    <= i_cmd_op;
            alu_ctrl_q  <= i_cmd_ctrl;
            alu_a_q     <= i_cmd_a;
            alu_b_q     <= i_cmd_b;
            alu_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the terminal-count cycle still wins.
          if (i_alu_done) begin
            res_data_q    <= i_alu_data;
            res_comp_q    <= i_alu_comp;
            res_invalid_q <= i_alu_invalid;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b1;
            state_q       <= ST_RESP;
          end else if (tmo_tc) begin
            res_data_q    <= '0;
            res_comp_q    <= 1'b0;
            res_invalid_q <= 1'b1;
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            state_q       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (i_res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign o_cmd_ready   = (state_q == ST_IDLE);
  assign o_alu_valid   = alu_valid_q;
  assign o_alu_op      = alu_op_q;
  assign o_alu_ctrl    = alu_ctrl_q;
  assign o_alu_a       = alu_a_q;
  assign o_alu_b       = alu_b_q;
  assign o_res_valid   = res_valid_q;
  assign o_res_data    = res_data_q;
  assign o_res_comp    = res_comp_q;
  assign o_res_invalid = res_invalid_q;
  assign o_res_timeout = res_timeout_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [CNT_W-1:0] stat_issued_q;
  logic [CNT_W-1:0] stat_invalid_q;
  logic [CNT_W-1:0] stat_timeout_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stat_issued_q  <= '0;
      stat_invalid_q <= '0;
      stat_timeout_q <= '0;
    end else begin
      if (state_q == ST_ISSUE && stat_issued_q != '1) begin
        stat_issued_q <= stat_issued_q + 1'b1;
      end
      if (state_q == ST_WAIT && i_alu_done && i_alu_invalid && stat_invalid_q != '1) begin
        stat_invalid_q <= stat_invalid_q + 1'b1;
      end
      if (state_q == ST_WAIT && !i_alu_done && tmo_tc && stat_timeout_q != '1) begin
        stat_timeout_q <= stat_timeout_q + 1'b1;
      end
    end
  end

  assign o_stat_issued  = stat_issued_q;
  assign o_stat_invalid = stat_invalid_q;
  assign o_stat_timeout = stat_timeout_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed handshake cases plus randomized traffic against a latency/result model.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [2:0]    i_cmd_op;
  logic [2:0]    i_cmd_ctrl;
  logic [DW-1:0] i_cmd_a;
  logic [DW-1:0] i_cmd_b;
  logic          o_alu_valid;
  logic [2:0]    o_alu_op;
  logic [2:0]    o_alu_ctrl;
  logic [DW-1:0] o_alu_a;
  logic [DW-1:0] o_alu_b;
  logic          i_alu_done;
  logic [DW-1:0] i_alu_data;
  logic          i_alu_comp;
  logic          i_alu_invalid;
  logic          o_res_valid;
  logic          i_res_ready;
  logic [DW-1:0] o_res_data;
  logic          o_res_comp;
  logic          o_res_invalid;
  logic          o_res_timeout;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]   o_stat_issued;
  logic [15:0]   o_stat_invalid;
  logic [15:0]   o_stat_timeout;
`endif

  alu_issue_ctrl #(.DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_op      (i_cmd_op),
    .i_cmd_ctrl    (i_cmd_ctrl),
    .i_cmd_a       (i_cmd_a),
    .i_cmd_b       (i_cmd_b),
    .o_alu_valid   (o_alu_valid),
    .o_alu_op      (o_alu_op),
    .o_alu_ctrl    (o_alu_ctrl),
    .o_alu_a       (o_alu_a),
    .o_alu_b       (o_alu_b),
    .i_alu_done    (i_alu_done),
    .i_alu_data    (i_alu_data),
    .i_alu_comp    (i_alu_comp),
    .i_alu_invalid (i_alu_invalid),
    .o_res_valid   (o_res_valid),
    .i_res_ready   (i_res_ready),
    .o_res_data    (o_res_data),
    .o_res_comp    (o_res_comp),
    .o_res_invalid (o_res_invalid),
    .o_res_timeout (o_res_timeout)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .o_stat_issued  (o_stat_issued),
    .o_stat_invalid (o_stat_invalid),
    .o_stat_timeout (o_stat_timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic [2:0]    ctrl;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          comp;
    logic          inv;
    logic          to;
    int            rise;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulses = 0;

  // Directed-test overrides for the ALU model and the result sink.
  bit            force_en   = 1'b0;
  int            force_lat  = 1;
  logic [DW-1:0] force_data = '0;
  logic          force_inv  = 1'b0;
  int            ready_mode = 1;   // 0 random, 1 always, 2 never

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ALU model: done arrives L cycles after the pulse; a new pulse abandons any outstanding op.
  initial begin
    bit   busy;
    bit   prev;
    int   left;
    cmd_t c;
    rsp_t r;
    logic [DW-1:0] d;
    logic cm, iv;
    int   lat;
    busy = 0; prev = 0; left = 0; d = '0; cm = 0; iv = 0;
    i_alu_done = 0; i_alu_data = '0; i_alu_comp = 0; i_alu_invalid = 0;
    forever begin
      @(negedge clk);
      i_alu_done    = 1'b0;
      i_alu_data    = $urandom;
      i_alu_comp    = 1'($urandom % 2);
      i_alu_invalid = 1'($urandom % 2);
      if (rst) begin
        prev = 0;
        continue;
      end
      if (o_alu_valid) begin
        check("pulse_width", prev, 0);
        pulses++;
        check("pulse_has_cmd", cmd_q.size() > 0, 1);
        if (cmd_q.size() > 0) begin
          c = cmd_q.pop_front();
          check("alu_a", o_alu_a, c.a);
          check("alu_b", o_alu_b, c.b);
          check("alu_opctl", {o_alu_op, o_alu_ctrl}, {c.op, c.ctrl});
        end
        lat = force_en ? force_lat : int'($urandom_range(1, 20));
        d   = force_en ? force_data : $urandom;
        cm  = force_en ? 1'b0 : 1'($urandom % 2);
        iv  = force_en ? force_inv : ($urandom % 4 == 0);
        if (lat <= TO) begin
          r.data = d; r.comp = cm; r.inv = iv; r.to = 1'b0;
          r.rise = cyc + lat + 1;
        end else begin
          r.data = '0; r.comp = 1'b0; r.inv = 1'b1; r.to = 1'b1;
          r.rise = cyc + TO + 1;
        end
        rsp_q.push_back(r);
        busy = 1; left = lat;
      end else if (busy) begin
        left--;
        if (left == 0) begin
          i_alu_done = 1'b1; i_alu_data = d; i_alu_comp = cm; i_alu_invalid = iv;
          busy = 0;
        end
      end
      prev = o_alu_valid;
    end
  end

  // Result sink: checks rise time, stability under backpressure and value at handshake.
  initial begin
    bit   pv;
    bit   taken;
    bit   rd;
    logic [DW+2:0] last;
    logic [DW+2:0] cur;
    rsp_t r;
    pv = 0; taken = 0; last = '0; i_res_ready = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0; taken = 0; i_res_ready = 0;
        continue;
      end
      if (taken) begin
        check("res_drop", o_res_valid, 0);
        check("rdy_after_res", o_cmd_ready, 1);
      end
      cur = {o_res_data, o_res_comp, o_res_invalid, o_res_timeout};
      if (o_res_valid) begin
        if (!pv) begin
          check("res_expected", rsp_q.size() > 0, 1);
          if (rsp_q.size() > 0) check("res_latency", cyc, rsp_q[0].rise);
        end else begin
          check("res_stable", cur, last);
          check("bp_cmd_rdy", o_cmd_ready, 0);
        end
      end
      rd = (ready_mode == 0) ? 1'($urandom % 2) : (ready_mode == 1);
      taken = o_res_valid && rd;
      if (taken && rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        check("res_value", cur, {r.data, r.comp, r.inv, r.to});
      end
      pv = o_res_valid;
      last = cur;
      i_res_ready = rd;
    end
  end

  // Called at a negedge; returns at the negedge of the ISSUE cycle.
  task automatic send_cmd(input logic [2:0] op, input logic [2:0] ctrl,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    cmd_t c;
    c.op = op; c.ctrl = ctrl; c.a = a; c.b = b;
    i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_ctrl = ctrl; i_cmd_a = a; i_cmd_b = b;
    for (int k = 0; k < 400; k++) begin
      if (o_cmd_ready) begin
        cmd_q.push_back(c);
        @(negedge clk);
        i_cmd_valid = 1'b0;
        i_cmd_a = $urandom; i_cmd_b = $urandom;
        return;
      end
      @(negedge clk);
    end
    check("cmd_accept", o_cmd_ready, 1);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (o_cmd_ready && !o_res_valid && rsp_q.size() == 0 && cmd_q.size() == 0) return;
    end
    check("wait_idle", o_cmd_ready, 1);
  endtask

  initial begin
    int p0;
    int p_rst;
    rst = 1'b1;
    i_cmd_valid = 0; i_cmd_op = '0; i_cmd_ctrl = '0; i_cmd_a = '0; i_cmd_b = '0;
    @(negedge clk);
    check("rst_alu", {o_alu_valid, o_alu_op, o_alu_ctrl}, 0);
    check("rst_ab", {o_alu_a, o_alu_b}, 0);
    check("rst_res", {o_res_valid, o_res_data, o_res_comp, o_res_invalid, o_res_timeout}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", o_cmd_ready, 1);

    // FSUB 3.0 - 1.0, ALU answers 4 cycles after the pulse.
    force_en = 1; force_lat = 4; force_data = 32'h4000_0000; force_inv = 0; ready_mode = 1;
    p0 = pulses;
    send_cmd(ALU_FSUB, 3'd3, 32'h4040_0000, 32'h3F80_0000);
    wait_idle();
    check("fsub_pulses", pulses - p0, 1);

    // Backpressure: result held for 10 cycles while a second command is offered.
    ready_mode = 2; force_lat = 3; force_data = 32'h1234_5678;
    p0 = pulses;
    send_cmd(ALU_FADD, 3'd1, 32'h3F80_0000, 32'h3F80_0000);
    for (int k = 0; k < 50 && !o_res_valid; k++) @(negedge clk);
    check("bp_res_vld", o_res_valid, 1);
    i_cmd_valid = 1'b1; i_cmd_op = ALU_FSUB; i_cmd_a = 32'hDEAD_BEEF;
    repeat (10) @(negedge clk);
    i_cmd_valid = 1'b0;
    ready_mode = 1;
    wait_idle();
    check("bp_pulses", pulses - p0, 1);

    // Timeout: the ALU answers at 12 cycles, past the limit; the late done must be dropped.
    force_lat = 12; force_data = 32'hCAFE_F00D;
    send_cmd(ALU_FADD, 3'd0, 32'h1111_1111, 32'h2222_2222);
    wait_idle();
    repeat (6) @(negedge clk);
    check("stray_done", o_res_valid, 0);
    force_lat = 2; force_data = 32'h4080_0000;
    send_cmd(ALU_FADD, 3'd2, 32'h4000_0000, 32'h4000_0000);
    wait_idle();

    // +Inf + -Inf reports invalid.
    force_lat = 5; force_data = 32'h7FC0_0000; force_inv = 1;
    send_cmd(ALU_FADD, 3'd0, 32'h7F80_0000, 32'hFF80_0000);
    wait_idle();
    force_inv = 0;

    // Asynchronous reset two cycles after issue; the in-flight done must be ignored.
    force_lat = 6; force_data = 32'h5555_AAAA;
    send_cmd(ALU_FSUB, 3'd4, 32'h3333_3333, 32'h4444_4444);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_alu", {o_alu_valid, o_alu_op, o_alu_ctrl}, 0);
    check("arst_ab", {o_alu_a, o_alu_b}, 0);
    check("arst_res", {o_res_valid, o_res_data, o_res_comp, o_res_invalid, o_res_timeout}, 0);
    rsp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    p_rst = pulses;
    @(negedge clk);
    check("rdy_after_arst", o_cmd_ready, 1);
    repeat (8) begin
      @(negedge clk);
      check("arst_stray", o_res_valid, 0);
    end
    force_lat = 1; force_data = 32'h0BAD_CAFE;
    send_cmd(ALU_FADD, 3'd5, 32'h0, 32'h0);
    wait_idle();

    // Randomized traffic: latency 1..20 (some time out), random sink readiness.
    force_en = 0; ready_mode = 0;
    p0 = pulses;
    for (int n = 0; n < 1024; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_cmd(($urandom % 2) ? ALU_FADD : ALU_FSUB, 3'($urandom), $urandom, $urandom);
    end
    ready_mode = 1;
    wait_idle();
    check("rnd_pulses", pulses - p0, 1024);

`ifdef ALU_ISSUE_STATS_EN
    check("stat_issued", o_stat_issued, pulses - p_rst);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the ALU valid/done handshake. It accepts one command (ALUOp, ALUctrl, operand A/B) from an upstream valid/ready port and issues a one-cycle i_valid pulse to the ALU. It holds the operands stable, waits for o_done with a timeout, and returns data/comp/invalid on a downstream valid/ready result port. It sits between the instruction decode/sequencer and the ALU, and serialises ALU use to one outstanding operation.

Parameters:
DATA_W, 32, operand/result width (IEEE-754 single for FP ops)
TIMEOUT_CYCLES, 64, WAIT-state cycles without o_done before a timeout response; legal range 2..65535
CNT_W, 16, width of the timeout counter and the optional statistics counters

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_cmd_valid  in  1  upstream command valid
o_cmd_ready  out  1  block can accept a command
i_cmd_op  in  3  ALUOp (FADD=4, FSUB=5, others passed through)
i_cmd_ctrl  in  3  ALUctrl
i_cmd_a  in  DATA_W  operand A
i_cmd_b  in  DATA_W  operand B
o_alu_valid  out  1  one-cycle issue pulse to the ALU
o_alu_op  out  3  registered ALUOp
o_alu_ctrl  out  3  registered ALUctrl
o_alu_a  out  DATA_W  registered operand A
o_alu_b  out  DATA_W  registered operand B
i_alu_done  in  1  ALU completion
i_alu_data  in  DATA_W  ALU result
i_alu_comp  in  1  ALU compare flag
i_alu_invalid  in  1  ALU invalid/exception flag
o_res_valid  out  1  result valid
i_res_ready  in  1  downstream accepts the result
o_res_data  out  DATA_W  captured result
o_res_comp  out  1  captured compare flag
o_res_invalid  out  1  captured invalid flag
o_res_timeout  out  1  response was produced by a timeout

Behaviour:
- Clock/reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset values: state IDLE; o_alu_valid=0; o_alu_op/ctrl/a/b=0; o_res_valid=0; o_res_data=0; o_res_comp/invalid/timeout=0; timeout counter=0.
- o_cmd_ready = (state==IDLE), combinational. It is 1 in the first cycle after reset release.
- IDLE: on i_cmd_valid & o_cmd_ready, register op/ctrl/a/b into o_alu_* and go to ISSUE.
- ISSUE: o_alu_valid=1 for exactly this cycle, counter cleared, then WAIT. An i_alu_done in this cycle is ignored, because ALU minimum latency is 1.
- WAIT:
  - o_alu_valid=0; o_alu_a/b/op/ctrl held unchanged until the next accept.
  - Counter increments each WAIT cycle.
  - If i_alu_done=1: capture data/comp/invalid, set timeout=0, go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: data=0, comp=0, invalid=1, timeout=1, go to RESP.
  - Done and timeout in the same cycle: done wins.
- RESP:
  - o_res_valid=1. Result fields are stable while valid and ~ready.
  - On i_res_ready: o_res_valid falls next cycle and the FSM returns to IDLE.
  - The next command can be accepted in the cycle after the result handshake; no overlap.
- Latency: o_alu_valid rises the cycle after command accept. o_res_valid rises the cycle after i_alu_done is sampled in WAIT.
- i_alu_done outside WAIT (IDLE, ISSUE, RESP) is ignored. A stray done after a timeout is therefore discarded.
- Reset mid-operation: immediate return to IDLE with reset values; any in-flight ALU result is dropped.
- Output flags are pass-through. NaN/overflow classification stays in the ALU.

Optional Feature:
ALU_ISSUE_STATS_EN:
- Defined: adds outputs o_stat_issued, o_stat_invalid and o_stat_timeout, each CNT_W wide.
  - Counters increment on an ISSUE cycle, on a captured invalid=1 done, and on a timeout, respectively.
  - They saturate at all-ones and clear on i_rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - ALUOp localparams (ALU_FADD=3'd4, ALU_FSUB=3'd5, and the rest).
  - The issue FSM state enum.
  - DATA_W default.
- One natural sub-module, alu_issue_timer: a loadable counter with a clear input and a terminal-count output, reused for the timeout counter.

Test Plan:
- FSUB basic: accept op=5, ctrl=3, a=0x40400000 (3.0), b=0x3F800000 (1.0); ALU model returns done 4 cycles after the pulse with 0x40000000 -> exactly one o_alu_valid pulse; o_res_valid one cycle after done; o_res_data=0x40000000, timeout=0.
- Backpressure: hold i_res_ready=0 for 10 cycles -> o_res_valid and o_res_data stay stable; o_cmd_ready stays 0; a new i_cmd_valid is not accepted.
- Timeout: TIMEOUT_CYCLES=8, ALU never answers -> response 8 WAIT cycles after issue with invalid=1, timeout=1, data=0. A later stray done is ignored, and the next command works normally.
- Invalid flag: FADD of a=0x7F800000 (+Inf) and b=0xFF800000 (-Inf); ALU returns invalid=1 -> o_res_invalid=1, timeout=0.
- Reset mid-WAIT: assert i_rst asynchronously 2 cycles after issue -> all outputs are at reset values before the next edge. After release o_cmd_ready=1, and a done arriving after release is ignored.
- Back-to-back: 1024 random FADD/FSUB pairs with random ALU latency 1..20 and random ready -> results in order, zero mismatches against the DW_fp_addsub model, one pulse per command.
